// File: rtl/key_debouncer_if.sv
// Pushbutton bundle between the raw KEY pins and the debounced event outputs.
// master drives KEY; slave is the debouncer that produces the cleaned levels and pulses.
interface key_debouncer_if #(
  parameter int NUM_KEYS = 3
);
  logic [NUM_KEYS-1:0] KEY;
  logic [NUM_KEYS-1:0] PRESSED;
  logic [NUM_KEYS-1:0] PRESS_P;
  logic [NUM_KEYS-1:0] RELEASE_P;
  logic [NUM_KEYS-1:0] REPEAT_P;

  modport master (output KEY, input PRESSED, PRESS_P, RELEASE_P, REPEAT_P);
  modport slave  (input KEY, output PRESSED, PRESS_P, RELEASE_P, REPEAT_P);
endinterface

// File: rtl/key_debouncer.sv
// Per-key synchronizer + stable-sample debounce FSM producing a level and press/release pulses.
// Optional auto-repeat pulses are built only when KEY_DEBOUNCER_AUTOREPEAT_EN is defined.
module key_debouncer #(
  parameter int NUM_KEYS        = 3,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic           CLOCK_50,
  input  logic           RESET_N,
  key_debouncer_if.slave kif
);
  localparam int              CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0]   CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PEND_DN = 2'd1,
    HELD    = 2'd2,
    PEND_UP = 2'd3
  } state_t;

  logic [NUM_KEYS-1:0] sync1_r;
  logic [NUM_KEYS-1:0] sync2_r;
  logic [NUM_KEYS-1:0] key_s;
  logic [NUM_KEYS-1:0] pressed_s;
  logic [NUM_KEYS-1:0] press_p_s;
  logic [NUM_KEYS-1:0] release_p_s;
  logic [NUM_KEYS-1:0] repeat_p_s;

  // two-flop synchronizer; resets to the released (high) pin level
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1_r <= {NUM_KEYS{1'b1}};
      sync2_r <= {NUM_KEYS{1'b1}};
    end else begin
      sync1_r <= kif.KEY;
      sync2_r <= sync1_r;
    end
  end

  assign key_s = ~sync2_r;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    state_t        state_r;
    logic [CW-1:0] cnt_r;
    logic          pressed_r;
    logic          press_p_r;
    logic          release_p_r;

    // debounce FSM: a change is accepted after DEBOUNCE_CYCLES consecutive equal samples
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
        state_r     <= IDLE;
        cnt_r       <= '0;
        pressed_r   <= 1'b0;
        press_p_r   <= 1'b0;
        release_p_r <= 1'b0;
      end else begin
        press_p_r   <= 1'b0;
        release_p_r <= 1'b0;
        case (state_r)
          IDLE: begin
            if (!key_s[k]) begin
              cnt_r <= '0;
            end else if (DEBOUNCE_CYCLES == 1) begin
              state_r   <= HELD;
              cnt_r     <= '0;
              pressed_r <= 1'b1;
              press_p_r <= 1'b1;
            end else begin
              state_r <= PEND_DN;
              cnt_r   <= CNT_ONE;
            end
          end
          PEND_DN: begin
            if (!key_s[k]) begin
              state_r <= IDLE;
              cnt_r   <= '0;
            end else if (cnt_r == DB_LAST) begin
              state_r   <= HELD;
              cnt_r     <= '0;
              pressed_r <= 1'b1;
              press_p_r <= 1'b1;
            end else begin
              cnt_r <= cnt_r + CNT_ONE;
            end
          end
          HELD: begin
            if (key_s[k]) begin
              cnt_r <= '0;
            end else if (DEBOUNCE_CYCLES == 1) begin
              state_r     <= IDLE;
              cnt_r       <= '0;
              pressed_r   <= 1'b0;
              release_p_r <= 1'b1;
            end else begin
              state_r <= PEND_UP;
              cnt_r   <= CNT_ONE;
            end
          end
          PEND_UP: begin
            if (key_s[k]) begin
              state_r <= HELD;
              cnt_r   <= '0;
            end else if (cnt_r == DB_LAST) begin
              state_r     <= IDLE;
              cnt_r       <= '0;
              pressed_r   <= 1'b0;
              release_p_r <= 1'b1;
            end else begin
              cnt_r <= cnt_r + CNT_ONE;
            end
          end
          default: begin
            state_r   <= IDLE;
            cnt_r     <= '0;
            pressed_r <= 1'b0;
          end
        endcase
      end
    end

    assign pressed_s[k]   = pressed_r;
    assign press_p_s[k]   = press_p_r;
    assign release_p_s[k] = release_p_r;

`ifdef KEY_DEBOUNCER_AUTOREPEAT_EN
    localparam int            RMAX    = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int            RW      = $clog2(RMAX + 1);
    localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0] rep_cnt_r;
    logic          rep_armed_r;
    logic          rep_p_r;
    logic          rel_acc_s;
    logic          rep_due_s;

    // release accepted on this edge: the repeat pulse is suppressed in that cycle
    assign rel_acc_s = !key_s[k] && ((state_r == PEND_UP && cnt_r == DB_LAST) ||
                                     (DEBOUNCE_CYCLES == 1 && state_r == HELD));
    assign rep_due_s = rep_armed_r ? (rep_cnt_r == RP_LAST) : (rep_cnt_r == RD_LAST);

    // repeat timer: first interval is REPEAT_DELAY, later ones REPEAT_PERIOD
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
        rep_cnt_r   <= '0;
        rep_armed_r <= 1'b0;
        rep_p_r     <= 1'b0;
      end else if ((state_r == HELD || state_r == PEND_UP) && !rel_acc_s) begin
        if (rep_due_s) begin
          rep_cnt_r   <= '0;
          rep_armed_r <= 1'b1;
          rep_p_r     <= 1'b1;
        end else begin
          rep_cnt_r   <= rep_cnt_r + RW'(1);
          rep_p_r     <= 1'b0;
        end
      end else begin
        rep_cnt_r   <= '0;
        rep_armed_r <= 1'b0;
        rep_p_r     <= 1'b0;
      end
    end

    assign repeat_p_s[k] = rep_p_r;
`else
    assign repeat_p_s[k] = 1'b0;
`endif
  end

  assign kif.PRESSED   = pressed_s;
  assign kif.PRESS_P   = press_p_s;
  assign kif.RELEASE_P = release_p_s;
  assign kif.REPEAT_P  = repeat_p_s;
endmodule
